fsm_4s1i1o_mo_tbl1_seq: RTL and testbench
=========================================

Name: fsm_4s1i1o_mo_tbl1_seq

Overview:
- Sequential wrapper around the 4-state, 1-input, 1-output Moore next-state/output table; sits directly around the combinational stage.
- Owns the 2-bit state register: feeds `state` into the table and registers the table's `state_next`.
- Accepts input bits over a val/rdy stream and emits the Moore output over a val/rdy stream.
- Keeps a saturating count of detected sequences, i.e. entries into state D.

Parameters:
- CNT_W, 8, width of match_count; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  input bit valid.
- in_rdy  output  1  block can accept an input bit this cycle.
- in_  input  1  FSM input bit.
- out_val  output  1  registered output valid.
- out_rdy  input  1  consumer accepts the output this cycle.
- out  output  1  Moore output of the state entered on the accepted input.
- state  output  2  current FSM state, direct register output.
- clear  input  1  synchronous clear of match_count.
- match_count  output  CNT_W  saturating count of accepted transitions into D.

Behaviour:
- States, 2-bit encoding: A=0, B=1, C=2, D=3. Moore output is 1 only in D.
- Transition table (next for in_=0 / in_=1):
  - A: A / B
  - B: C / B
  - C: A / D
  - D: C / B
- Reset, asynchronous, any time including mid-stream: state=A, out_val=0, out=0, match_count=0. Outputs take reset values immediately; operation resumes on the first rising edge after deassertion.
- in_rdy = !out_val || out_rdy. This is combinational and forms a single-entry output skid, so there is no bubble under continuous ready.
- Input is accepted when in_val && in_rdy. On that edge:
  - state <= next(state, in_)
  - out <= (next == D)
  - out_val <= 1
- No accept but out_val && out_rdy: out_val <= 0; out holds its last value.
- No accept and no drain: all registers hold. out and out_val are stable while out_val && !out_rdy.
- Latency: 1 cycle from accepted input to out_val. Throughput: 1 bit/cycle with out_rdy tied high.
- in_ is ignored whenever in_val=0 or in_rdy=0. state never changes without an accept.
- match_count:
  - Increments by 1 on an accept whose next state is D.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clear=1 forces 0 on the next edge and takes priority over a simultaneous increment.
  - clear does not affect the FSM or the streams.
- out reflects the state entered. Re-entering D from C on consecutive matches (e.g. 1,0,1,0,1) counts each entry.
- No X propagation: every register has a reset value. Outputs are undefined for no input combination.

Decomposition:
- Shared package fsm_tbl1_pkg:
  - state typedef (2-bit enum A/B/C/D)
  - localparams STATE_A..STATE_D
  - function out_of_state
- Sub-module fsm_4s1i1o_mo_tbl1_comb: purely combinational, ports state, in_, state_next, out. It encodes the table above.
- The top instantiates the sub-module and adds the state register, output skid register and counter. Keep the sub-module separately testable.

Test Plan:
1. Reset → state=0, out_val=0, match_count=0 immediately. Assert reset mid-stream while out_val=1 → all three return to reset values before the next edge.
2. out_rdy=1, in_val=1, in_ bits 1,0,1 on consecutive cycles → state 1,2,3. out_val=1 from the cycle after the first accept; out = 0,0,1; match_count=1.
3. out_rdy=1, bits 1,0,1,0,1 → out = 0,0,1,0,1; match_count=2. Exhaustively drive all 8 (state,in_) pairs via reset+prefix and check state_next against the table.
4. Backpressure: out_rdy=0 after one accept → in_rdy=0, out and state frozen for 5 cycles even with toggling in_. Raise out_rdy → next bit accepted the same cycle; no bit lost or duplicated.
5. CNT_W=2: drive 4 matches → match_count saturates at 3. A 5th match keeps 3. Assert clear on the same cycle as a match → 0 on the next edge.
6. in_val=0 for 3 cycles with out_rdy=1 → out_val drops after one cycle, state unchanged. Resume with bit 1 from state C → state=3, out=1.

Source files
------------

// File: rtl/fsm_tbl1_pkg.sv
// Shared definitions for the 4-state, 1-input, 1-output Moore table FSM.
// Holds the state encoding and the Moore output decode used by both the table and its wrapper.
package fsm_tbl1_pkg;

   typedef enum logic [1:0] {
      ST_A = 2'd0,
      ST_B = 2'd1,
      ST_C = 2'd2,
      ST_D = 2'd3
   } state_t;

   localparam logic [1:0] STATE_A = 2'd0;
   localparam logic [1:0] STATE_B = 2'd1;
   localparam logic [1:0] STATE_C = 2'd2;
   localparam logic [1:0] STATE_D = 2'd3;

   function automatic logic out_of_state(input logic [1:0] s);
      return (s == STATE_D);
   endfunction

endpackage

// File: rtl/fsm_4s1i1o_mo_tbl1_comb.sv
// Purely combinational next-state table for the 4-state sequence detector.
// The out port is the Moore output of the state being entered, so the wrapper can register it directly.
module fsm_4s1i1o_mo_tbl1_comb
   import fsm_tbl1_pkg::*;
(
   input  logic [1:0] state,
   input  logic       in_,
   output logic [1:0] state_next,
   output logic       out
);

   state_t w_next;

   always_comb begin
      w_next = ST_A;
      case (state_t'(state))
         ST_A:    w_next = in_ ? ST_B : ST_A;
         ST_B:    w_next = in_ ? ST_B : ST_C;
         ST_C:    w_next = in_ ? ST_D : ST_A;
         ST_D:    w_next = in_ ? ST_B : ST_C;
         default: w_next = ST_A;
      endcase
   end

   assign state_next = w_next;
   assign out        = out_of_state(w_next);

endmodule

// File: rtl/fsm_4s1i1o_mo_tbl1_seq.sv
// Sequential wrapper: state register, single-entry output skid register and a
// saturating count of entries into state D, around the combinational table.
module fsm_4s1i1o_mo_tbl1_seq
   import fsm_tbl1_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic             in_,
   output logic             out_val,
   input  logic             out_rdy,
   output logic             out,
   output logic [1:0]       state,
   input  logic             clear,
   output logic [CNT_W-1:0] match_count
);

   logic [1:0]       r_state;
   logic             r_out;
   logic             r_outVal;
   logic [CNT_W-1:0] r_count;

   logic [1:0]       w_stateNext;
   logic             w_outNext;
   logic             w_accept;
   logic             w_match;

   fsm_4s1i1o_mo_tbl1_comb uComb (
      .state      (r_state),
      .in_        (in_),
      .state_next (w_stateNext),
      .out        (w_outNext)
   );

   // The output register can take a new bit whenever it is empty or being drained this cycle.
   assign in_rdy   = !r_outVal || out_rdy;
   assign w_accept = in_val && in_rdy;
   assign w_match  = w_accept && (w_stateNext == STATE_D);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= STATE_A;
         r_out    <= 1'b0;
         r_outVal <= 1'b0;
      end else if (w_accept) begin
         r_state  <= w_stateNext;
         r_out    <= w_outNext;
         r_outVal <= 1'b1;
      end else if (r_outVal && out_rdy) begin
         r_outVal <= 1'b0;
      end
   end

   // Clear wins over a simultaneous match; the count sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign state       = r_state;
   assign out         = r_out;
   assign out_val     = r_outVal;
   assign match_count = r_count;

endmodule

// File: tb/tb_fsm_4s1i1o_mo_tbl1_seq.sv
// Directed bench for the sequence-detector wrapper: a table of (state, bit) transitions
// plus hand-written sequences for streaming, backpressure, reset and counter saturation.
module tb_fsm_4s1i1o_mo_tbl1_seq;

   typedef struct {
      logic [1:0] fromState;
      logic       inBit;
      logic [1:0] expNext;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       in_val;
   logic       in_;
   logic       out_rdy;
   logic       clear;

   logic       in_rdy;
   logic       out_val;
   logic       out;
   logic [1:0] state;
   logic [7:0] match_count;

   logic       in_rdyB;
   logic       out_valB;
   logic       outB;
   logic [1:0] stateB;
   logic [1:0] match_countB;

   int nCompared   = 0;
   int nMismatched = 0;

   vec_t vecs [8];

   fsm_4s1i1o_mo_tbl1_seq #(.CNT_W(8)) dutA (
      .clk         (clk),
      .reset       (reset),
      .in_val      (in_val),
      .in_rdy      (in_rdy),
      .in_         (in_),
      .out_val     (out_val),
      .out_rdy     (out_rdy),
      .out         (out),
      .state       (state),
      .clear       (clear),
      .match_count (match_count)
   );

   fsm_4s1i1o_mo_tbl1_seq #(.CNT_W(2)) dutB (
      .clk         (clk),
      .reset       (reset),
      .in_val      (in_val),
      .in_rdy      (in_rdyB),
      .in_         (in_),
      .out_val     (out_valB),
      .out_rdy     (out_rdy),
      .out         (outB),
      .state       (stateB),
      .clear       (clear),
      .match_count (match_countB)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle of stream inputs, take the rising edge, and return 1 time unit after it.
   task automatic applyStimulus(input logic v, input logic b, input logic r);
      in_val  = v;
      in_     = b;
      out_rdy = r;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed mid-cycle, well clear of any edge.
   task automatic pulseReset();
      in_val = 1'b0;
      reset  = 1'b1;
      #2;
      reset  = 1'b0;
   endtask

   task automatic drivePrefix(input logic [1:0] target);
      case (target)
         2'd1: applyStimulus(1'b1, 1'b1, 1'b1);
         2'd2: begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            applyStimulus(1'b1, 1'b0, 1'b1);
         end
         2'd3: begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            applyStimulus(1'b1, 1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b1);
         end
         default: ;
      endcase
   endtask

   initial begin
      vecs[0] = '{2'd0, 1'b0, 2'd0};
      vecs[1] = '{2'd0, 1'b1, 2'd1};
      vecs[2] = '{2'd1, 1'b0, 2'd2};
      vecs[3] = '{2'd1, 1'b1, 2'd1};
      vecs[4] = '{2'd2, 1'b0, 2'd0};
      vecs[5] = '{2'd2, 1'b1, 2'd3};
      vecs[6] = '{2'd3, 1'b0, 2'd2};
      vecs[7] = '{2'd3, 1'b1, 2'd1};

      reset   = 1'b1;
      in_val  = 1'b0;
      in_     = 1'b0;
      out_rdy = 1'b1;
      clear   = 1'b0;
      #3;
      checkOutput("reset state", state, 0);
      checkOutput("reset out_val", out_val, 0);
      checkOutput("reset out", out, 0);
      checkOutput("reset match_count", match_count, 0);
      checkOutput("reset in_rdy", in_rdy, 1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Stream 1,0,1,0,1 with the consumer always ready.
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("s1 state", state, 1);
      checkOutput("s1 out_val", out_val, 1);
      checkOutput("s1 out", out, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("s2 state", state, 2);
      checkOutput("s2 out", out, 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("s3 state", state, 3);
      checkOutput("s3 out", out, 1);
      checkOutput("s3 count", match_count, 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("s4 state", state, 2);
      checkOutput("s4 out", out, 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("s5 state", state, 3);
      checkOutput("s5 out", out, 1);
      checkOutput("s5 out_val", out_val, 1);
      checkOutput("s5 count", match_count, 2);

      // Mid-stream asynchronous reset while out_val is high.
      in_val = 1'b0;
      reset  = 1'b1;
      #2;
      checkOutput("midreset state", state, 0);
      checkOutput("midreset out_val", out_val, 0);
      checkOutput("midreset out", out, 0);
      checkOutput("midreset count", match_count, 0);
      reset = 1'b0;

      // Every (state, bit) pair reached by reset plus a prefix.
      for (int i = 0; i < 8; i++) begin
         pulseReset();
         drivePrefix(vecs[i].fromState);
         checkOutput($sformatf("tbl%0d from", i), state, vecs[i].fromState);
         applyStimulus(1'b1, vecs[i].inBit, 1'b1);
         checkOutput($sformatf("tbl%0d next", i), state, vecs[i].expNext);
         checkOutput($sformatf("tbl%0d out", i), out, (vecs[i].expNext == 2'd3) ? 1 : 0);
      end

      // Backpressure: output held, input refused, state frozen while in_ toggles.
      pulseReset();
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("bp accept state", state, 1);
      checkOutput("bp accept out_val", out_val, 1);
      for (int i = 0; i < 5; i++) begin
         in_val  = 1'b1;
         in_     = i[0];
         out_rdy = 1'b0;
         #1;
         checkOutput($sformatf("bp%0d in_rdy", i), in_rdy, 0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp%0d state", i), state, 1);
         checkOutput($sformatf("bp%0d out_val", i), out_val, 1);
         checkOutput($sformatf("bp%0d out", i), out, 0);
      end
      in_val  = 1'b1;
      in_     = 1'b0;
      out_rdy = 1'b1;
      #1;
      checkOutput("bp release in_rdy", in_rdy, 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("bp release state", state, 2);
      checkOutput("bp release out_val", out_val, 1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("bp after state", state, 3);
      checkOutput("bp after out", out, 1);
      checkOutput("bp after count", match_count, 1);

      // Saturation on the narrow counter, and clear racing a match.
      pulseReset();
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         applyStimulus(1'b1, 1'b1, 1'b1);
      end
      checkOutput("sat4 countA", match_count, 4);
      checkOutput("sat4 countB", match_countB, 3);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("sat5 countA", match_count, 5);
      checkOutput("sat5 countB", match_countB, 3);
      applyStimulus(1'b1, 1'b0, 1'b1);
      clear = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1);
      clear = 1'b0;
      checkOutput("clear countA", match_count, 0);
      checkOutput("clear countB", match_countB, 0);
      checkOutput("clear state", state, 3);
      checkOutput("clear out", out, 1);

      // Idle gap: out_val drains, state holds even though in_ wiggles, then resume from C.
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("idle pre state", state, 2);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkOutput($sformatf("idle%0d state", i), state, 2);
         checkOutput($sformatf("idle%0d out_val", i), out_val, 0);
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("resume state", state, 3);
      checkOutput("resume out", out, 1);
      checkOutput("resume out_val", out_val, 1);
      checkOutput("resume count", match_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
